// File: rtl/fft_stage4_reorder.sv
// Last radix-2 layer of the 16-point FFT (W0 twiddle only), plus bit-reversal
// reorder that streams X[0]..X[15] one beat at a time under valid/ready.

module fft_s4_bfly #(
  parameter int DW = 16
) (
  input  logic [2*DW-1:0] a,
  input  logic [2*DW-1:0] b,
  output logic [2*DW-1:0] sum,
  output logic [2*DW-1:0] dif
);
  // Real and imag halves wrap independently; no growth, no scaling.
  assign sum = {a[2*DW-1:DW] + b[2*DW-1:DW], a[DW-1:0] + b[DW-1:0]};
  assign dif = {a[2*DW-1:DW] - b[2*DW-1:DW], a[DW-1:0] - b[DW-1:0]};
endmodule

module fft_stage4_reorder #(
  parameter int DW  = 16,
  parameter int NPT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2*DW-1:0] stage4_data0_in,
  input  logic [2*DW-1:0] stage4_data1_in,
  input  logic [2*DW-1:0] stage4_data2_in,
  input  logic [2*DW-1:0] stage4_data3_in,
  input  logic [2*DW-1:0] stage4_data4_in,
  input  logic [2*DW-1:0] stage4_data5_in,
  input  logic [2*DW-1:0] stage4_data6_in,
  input  logic [2*DW-1:0] stage4_data7_in,
  input  logic [2*DW-1:0] stage4_data8_in,
  input  logic [2*DW-1:0] stage4_data9_in,
  input  logic [2*DW-1:0] stage4_data10_in,
  input  logic [2*DW-1:0] stage4_data11_in,
  input  logic [2*DW-1:0] stage4_data12_in,
  input  logic [2*DW-1:0] stage4_data13_in,
  input  logic [2*DW-1:0] stage4_data14_in,
  input  logic [2*DW-1:0] stage4_data15_in,
  output logic          fft_valid,
  input  logic          out_ready,
  output logic [DW-1:0] fft_real,
  output logic [DW-1:0] fft_img,
  output logic [3:0]    fft_index,
  output logic          fft_last
);
  localparam int NB = NPT / 2;

  typedef enum logic {IDLE, EMIT} state_t;

  logic [NPT-1:0][2*DW-1:0] din, bfly, bufr;
  logic [2*DW-1:0]          rd;
  logic [3:0]               cnt, cnt_nxt, rd_idx;
  state_t                   state, state_nxt;
  logic                     accept;

  assign din = {stage4_data15_in, stage4_data14_in, stage4_data13_in, stage4_data12_in,
                stage4_data11_in, stage4_data10_in, stage4_data9_in,  stage4_data8_in,
                stage4_data7_in,  stage4_data6_in,  stage4_data5_in,  stage4_data4_in,
                stage4_data3_in,  stage4_data2_in,  stage4_data1_in,  stage4_data0_in};

  for (genvar k = 0; k < NB; k++) begin : g_bfly
    fft_s4_bfly #(.DW(DW)) u_bfly (
      .a   (din[2*k]),
      .b   (din[2*k+1]),
      .sum (bfly[2*k]),
      .dif (bfly[2*k+1])
    );
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = EMIT;
          cnt_nxt   = 4'd0;
        end
      end
      EMIT: begin
        // Last beat leaving frees the buffer in the same cycle: no bubble.
        in_ready = (cnt == 4'hF) && out_ready;
        if (out_ready) begin
          cnt_nxt = cnt + 4'd1;
          if (cnt == 4'hF && !in_valid) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      bufr  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) bufr <= bfly;
    end
  end

  assign rd_idx    = {cnt[0], cnt[1], cnt[2], cnt[3]};
  assign rd        = bufr[rd_idx];
  assign fft_valid = (state == EMIT);
  assign fft_index = cnt;
  assign fft_last  = fft_valid && (cnt == 4'hF);
  assign fft_real  = rd[2*DW-1:DW];
  assign fft_img   = rd[DW-1:0];
endmodule

// File: tb/tb_fft_stage4_reorder.sv
// Directed + random frames for fft_stage4_reorder, checked against a reference
// DFT-stage model computed from the frame held in the bench.

module tb_fft_stage4_reorder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, fft_valid, out_ready, fft_last;
  logic [31:0] din [16];
  logic [15:0] fft_real, fft_img;
  logic [3:0]  fft_index;

  logic [31:0] cur [16];
  logic [31:0] nxt [16];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fft_stage4_reorder #(.DW(16), .NPT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .stage4_data0_in(din[0]),   .stage4_data1_in(din[1]),   .stage4_data2_in(din[2]),
    .stage4_data3_in(din[3]),   .stage4_data4_in(din[4]),   .stage4_data5_in(din[5]),
    .stage4_data6_in(din[6]),   .stage4_data7_in(din[7]),   .stage4_data8_in(din[8]),
    .stage4_data9_in(din[9]),   .stage4_data10_in(din[10]), .stage4_data11_in(din[11]),
    .stage4_data12_in(din[12]), .stage4_data13_in(din[13]), .stage4_data14_in(din[14]),
    .stage4_data15_in(din[15]),
    .fft_valid(fft_valid), .out_ready(out_ready), .fft_real(fft_real), .fft_img(fft_img),
    .fft_index(fft_index), .fft_last(fft_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bin f of the output is the butterfly result at position bitrev(f).
  function automatic logic [31:0] exp_bin(input int f);
    int j;
    logic [15:0] ar, ai, br, bi;
    j  = ((f & 1) << 3) | ((f & 2) << 1) | ((f & 4) >> 1) | ((f & 8) >> 3);
    ar = cur[j & 14][31:16];   ai = cur[j & 14][15:0];
    br = cur[(j & 14) + 1][31:16]; bi = cur[(j & 14) + 1][15:0];
    if ((j % 2) == 0) return {ar + br, ai + bi};
    else              return {ar - br, ai - bi};
  endfunction

  task automatic clear_cur();
    for (int i = 0; i < 16; i++) cur[i] = 32'h0;
  endtask

  task automatic rand_cur();
    for (int i = 0; i < 16; i++) cur[i] = $urandom();
  endtask

  task automatic start_frame();
    chk("start_rdy", in_ready, 1);
    for (int i = 0; i < 16; i++) din[i] = cur[i];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic emit(input int stall_at, input bit chain, input bit noise);
    logic [31:0] e;
    for (int b = 0; b < 16; b++) begin
      e = exp_bin(b);
      chk("valid", fft_valid, 1);
      chk("index", fft_index, b);
      chk("real", fft_real, e[31:16]);
      chk("img", fft_img, e[15:0]);
      chk("last", fft_last, b == 15);
      chk("beat_rdy", in_ready, b == 15);
      if (b == stall_at) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_valid", fft_valid, 1);
          chk("stall_idx", fft_index, b);
          chk("stall_real", fft_real, e[31:16]);
          chk("stall_img", fft_img, e[15:0]);
          chk("stall_last", fft_last, b == 15);
          chk("stall_rdy", in_ready, 0);
        end
        out_ready = 1'b1;
      end
      if (noise) begin
        // Offered frame while busy must be ignored.
        in_valid = (b < 13);
        for (int i = 0; i < 16; i++) din[i] = $urandom();
      end
      if (b == 15 && chain) begin
        chk("b2b_rdy", in_ready, 1);
        for (int i = 0; i < 16; i++) din[i] = nxt[i];
        in_valid = 1'b1;
      end
      @(negedge clk);
      if (b == 15 && chain) begin
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) cur[i] = nxt[i];
      end
    end
    if (!chain) begin
      chk("idle_valid", fft_valid, 0);
      chk("idle_rdy", in_ready, 1);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) din[i] = $urandom();
    repeat (2) @(negedge clk);
    chk("rst_valid", fft_valid, 0);
    chk("rst_index", fft_index, 0);
    chk("rst_real", fft_real, 0);
    chk("rst_img", fft_img, 0);
    chk("rst_last", fft_last, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", in_ready, 1);

    // Impulse
    clear_cur(); cur[0] = 32'h0100_0000;
    start_frame(); emit(-1, 0, 0);
    // Pair difference
    clear_cur(); cur[1] = 32'h0001_0002;
    start_frame(); emit(-1, 0, 0);
    // Wrap-around
    clear_cur(); cur[2] = 32'h7FFF_8000; cur[3] = 32'h0001_0001;
    start_frame(); emit(-1, 0, 0);
    // Stall at index 5, with junk offered upstream meanwhile
    rand_cur();
    start_frame(); emit(5, 0, 1);
    // Back-to-back A -> B, then B stalls on its last beat
    rand_cur();
    for (int i = 0; i < 16; i++) nxt[i] = $urandom();
    start_frame(); emit(-1, 1, 0);
    emit(15, 0, 0);

    // Reset mid-frame at index 7
    rand_cur();
    start_frame();
    repeat (7) @(negedge clk);
    chk("pre_rst_idx", fft_index, 7);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_valid", fft_valid, 0);
    chk("mrst_index", fft_index, 0);
    chk("mrst_rdy", in_ready, 1);
    chk("mrst_real", fft_real, 0);
    rst = 1'b0;
    rand_cur();
    start_frame(); emit(-1, 0, 0);

    // Random frames with random stall points
    for (int n = 0; n < 4; n++) begin
      rand_cur();
      start_frame(); emit($urandom_range(0, 15), 0, n[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
